// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Captures decoded controls and forwarded operands once per cycle.
module id_ex_stage (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        InValid,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  DestRegister,
    input  logic        RegWriteIn,
    input  logic        MemReadIn,
    input  logic        UseImm,
    input  logic [31:0] Imm,
    input  logic        ExMemRegWrite,
    input  logic        MemWbRegWrite,
    input  logic [4:0]  ExMemDest,
    input  logic [4:0]  MemWbDest,
    input  logic [31:0] ExMemResult,
    input  logic [31:0] MemWbResult,
    output logic        OutValid,
    output logic        OutRegWrite,
    output logic        OutMemRead,
    output logic [31:0] OperandA,
    output logic [31:0] OperandB,
    output logic [31:0] StoreData,
    output logic [4:0]  OutDest,
    output logic [1:0]  FwdSelA,
    output logic [1:0]  FwdSelB,
    output logic        HazardStall
);

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EXM  = 2'd1;
    localparam logic [1:0] FWD_MWB  = 2'd2;

    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        exm_a;
    logic        exm_b;
    logic        mwb_a;
    logic        mwb_b;

    // Forward source selection: newest producer (ExMem) wins; x0 never forwards.
    always_comb begin
        exm_a = ExMemRegWrite && (ExMemDest == ReadRegister1)
                && (ReadRegister1 != 5'd0);
        exm_b = ExMemRegWrite && (ExMemDest == ReadRegister2)
                && (ReadRegister2 != 5'd0);
        mwb_a = MemWbRegWrite && (MemWbDest == ReadRegister1)
                && (ReadRegister1 != 5'd0);
        mwb_b = MemWbRegWrite && (MemWbDest == ReadRegister2)
                && (ReadRegister2 != 5'd0);
        sel_a = FWD_RF;
        fwd_a = ReadData1;
        sel_b = FWD_RF;
        fwd_b = ReadData2;
        if (exm_a) begin
            sel_a = FWD_EXM;
            fwd_a = ExMemResult;
        end else if (mwb_a) begin
            sel_a = FWD_MWB;
            fwd_a = MemWbResult;
        end
        if (exm_b) begin
            sel_b = FWD_EXM;
            fwd_b = ExMemResult;
        end else if (mwb_b) begin
            sel_b = FWD_MWB;
            fwd_b = MemWbResult;
        end
    end

    // Load-use hazard: a load in this stage feeds either source of decode.
    always_comb begin
        HazardStall = OutValid && OutMemRead && InValid
                      && (OutDest != 5'd0)
                      && ((OutDest == ReadRegister1)
                          || (OutDest == ReadRegister2));
    end

    // Pipeline register: flush beats stall beats bubble beats capture.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid    <= 1'b0;
            OutRegWrite <= 1'b0;
            OutMemRead  <= 1'b0;
            OperandA    <= 32'd0;
            OperandB    <= 32'd0;
            StoreData   <= 32'd0;
            OutDest     <= 5'd0;
            FwdSelA     <= 2'd0;
            FwdSelB     <= 2'd0;
        end else if (Flush) begin
            OutValid    <= 1'b0;
            OutRegWrite <= 1'b0;
            OutMemRead  <= 1'b0;
            OperandA    <= 32'd0;
            OperandB    <= 32'd0;
            StoreData   <= 32'd0;
            OutDest     <= 5'd0;
            FwdSelA     <= 2'd0;
            FwdSelB     <= 2'd0;
        end else if (Stall) begin
            OutValid    <= OutValid;
        end else if (HazardStall) begin
            OutValid    <= 1'b0;
            OutRegWrite <= 1'b0;
            OutMemRead  <= 1'b0;
            OutDest     <= 5'd0;
        end else begin
            OutValid    <= InValid;
            OutRegWrite <= InValid && RegWriteIn;
            OutMemRead  <= InValid && MemReadIn;
            OperandA    <= fwd_a;
            OperandB    <= UseImm ? Imm : fwd_b;
            StoreData   <= fwd_b;
            OutDest     <= DestRegister;
            FwdSelA     <= sel_a;
            FwdSelB     <= sel_b;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Each task drives one scenario and checks outputs after the edge.
module tb_id_ex_stage;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        Stall;
    logic        Flush;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  DestRegister;
    logic        RegWriteIn;
    logic        MemReadIn;
    logic        UseImm;
    logic [31:0] Imm;
    logic        ExMemRegWrite;
    logic        MemWbRegWrite;
    logic [4:0]  ExMemDest;
    logic [4:0]  MemWbDest;
    logic [31:0] ExMemResult;
    logic [31:0] MemWbResult;
    logic        OutValid;
    logic        OutRegWrite;
    logic        OutMemRead;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [31:0] StoreData;
    logic [4:0]  OutDest;
    logic [1:0]  FwdSelA;
    logic [1:0]  FwdSelB;
    logic        HazardStall;

    int passed;
    int total;

    id_ex_stage dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .InValid(InValid),
        .Stall(Stall),
        .Flush(Flush),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .DestRegister(DestRegister),
        .RegWriteIn(RegWriteIn),
        .MemReadIn(MemReadIn),
        .UseImm(UseImm),
        .Imm(Imm),
        .ExMemRegWrite(ExMemRegWrite),
        .MemWbRegWrite(MemWbRegWrite),
        .ExMemDest(ExMemDest),
        .MemWbDest(MemWbDest),
        .ExMemResult(ExMemResult),
        .MemWbResult(MemWbResult),
        .OutValid(OutValid),
        .OutRegWrite(OutRegWrite),
        .OutMemRead(OutMemRead),
        .OperandA(OperandA),
        .OperandB(OperandB),
        .StoreData(StoreData),
        .OutDest(OutDest),
        .FwdSelA(FwdSelA),
        .FwdSelB(FwdSelB),
        .HazardStall(HazardStall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        InValid       = 1'b0;
        Stall         = 1'b0;
        Flush         = 1'b0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        ReadData1     = 32'd0;
        ReadData2     = 32'd0;
        DestRegister  = 5'd0;
        RegWriteIn    = 1'b0;
        MemReadIn     = 1'b0;
        UseImm        = 1'b0;
        Imm           = 32'd0;
        ExMemRegWrite = 1'b0;
        MemWbRegWrite = 1'b0;
        ExMemDest     = 5'd0;
        MemWbDest     = 5'd0;
        ExMemResult   = 32'd0;
        MemWbResult   = 32'd0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        InValid = 1'b1;
        RegWriteIn = 1'b1;
        ReadData1 = 32'h1234_5678;
        DestRegister = 5'd3;
        Rst_n = 1'b0;
        step();
        step();
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutDest, FwdSelA, FwdSelB}
            !== 12'd0) begin
            $display("FAIL reset_ctrl got %b want 0",
                     {OutValid, OutRegWrite, OutMemRead, OutDest,
                      FwdSelA, FwdSelB});
        end else passed++;
        total++;
        if ({OperandA, OperandB, StoreData, HazardStall} !== 97'd0) begin
            $display("FAIL reset_data got %h %h %h %b want 0",
                     OperandA, OperandB, StoreData, HazardStall);
        end else passed++;
        Rst_n = 1'b1;
        clear_inputs();
        step();
        total++;
        if (OutValid !== 1'b0) begin
            $display("FAIL first_idle got %b want 0", OutValid);
        end else passed++;
    endtask

    task automatic test_no_forward();
        clear_inputs();
        InValid = 1'b1;
        RegWriteIn = 1'b1;
        ReadRegister1 = 5'd16;
        ReadData1 = 32'hDEAD_DAD5;
        ReadRegister2 = 5'd3;
        ReadData2 = 32'h1234_5678;
        DestRegister = 5'd7;
        ExMemRegWrite = 1'b1;
        ExMemDest = 5'd17;
        ExMemResult = 32'hBAD0_0001;
        MemWbRegWrite = 1'b1;
        MemWbDest = 5'd4;
        MemWbResult = 32'hBAD0_0002;
        step();
        total++;
        if (OperandA !== 32'hDEAD_DAD5 || FwdSelA !== 2'd0) begin
            $display("FAIL nofwd_a got %h/%0d want deaddad5/0",
                     OperandA, FwdSelA);
        end else passed++;
        total++;
        if (OperandB !== 32'h1234_5678 || StoreData !== 32'h1234_5678
            || FwdSelB !== 2'd0) begin
            $display("FAIL nofwd_b got %h/%h/%0d want 12345678/12345678/0",
                     OperandB, StoreData, FwdSelB);
        end else passed++;
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutDest} !== 8'b110_00111) begin
            $display("FAIL nofwd_ctrl got %b want 11000111",
                     {OutValid, OutRegWrite, OutMemRead, OutDest});
        end else passed++;
    endtask

    task automatic test_double_match();
        clear_inputs();
        InValid = 1'b1;
        ReadRegister1 = 5'd31;
        ReadData1 = 32'hAAAA_AAAA;
        ReadRegister2 = 5'd31;
        ReadData2 = 32'hBBBB_BBBB;
        UseImm = 1'b1;
        Imm = 32'hFFFF_FF80;
        DestRegister = 5'd2;
        ExMemRegWrite = 1'b1;
        ExMemDest = 5'd31;
        ExMemResult = 32'h1111_1111;
        MemWbRegWrite = 1'b1;
        MemWbDest = 5'd31;
        MemWbResult = 32'h2222_2222;
        step();
        total++;
        if (OperandA !== 32'h1111_1111 || FwdSelA !== 2'd1) begin
            $display("FAIL double_a got %h/%0d want 11111111/1",
                     OperandA, FwdSelA);
        end else passed++;
        total++;
        if (OperandB !== 32'hFFFF_FF80 || StoreData !== 32'h1111_1111
            || FwdSelB !== 2'd1) begin
            $display("FAIL imm_store got %h/%h/%0d want ffffff80/11111111/1",
                     OperandB, StoreData, FwdSelB);
        end else passed++;
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        InValid = 1'b1;
        ReadRegister1 = 5'd9;
        ReadData1 = 32'h0000_0009;
        ReadRegister2 = 5'd0;
        ReadData2 = 32'd0;
        ExMemRegWrite = 1'b1;
        ExMemDest = 5'd0;
        ExMemResult = 32'hFFFF_FFFF;
        MemWbRegWrite = 1'b1;
        MemWbDest = 5'd9;
        MemWbResult = 32'hCAFE_F00D;
        step();
        total++;
        if (OperandB !== 32'd0 || FwdSelB !== 2'd0) begin
            $display("FAIL reg0_b got %h/%0d want 0/0", OperandB, FwdSelB);
        end else passed++;
        total++;
        if (OperandA !== 32'hCAFE_F00D || FwdSelA !== 2'd2) begin
            $display("FAIL memwb_a got %h/%0d want cafef00d/2",
                     OperandA, FwdSelA);
        end else passed++;
    endtask

    task automatic test_invalid_capture();
        clear_inputs();
        InValid = 1'b0;
        RegWriteIn = 1'b1;
        MemReadIn = 1'b1;
        DestRegister = 5'd12;
        step();
        total++;
        if ({OutValid, OutRegWrite, OutMemRead} !== 3'b000) begin
            $display("FAIL invalid_ctrl got %b want 000",
                     {OutValid, OutRegWrite, OutMemRead});
        end else passed++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        InValid = 1'b1;
        RegWriteIn = 1'b1;
        MemReadIn = 1'b1;
        DestRegister = 5'd5;
        ReadRegister1 = 5'd1;
        step();
        clear_inputs();
        InValid = 1'b1;
        RegWriteIn = 1'b1;
        ReadRegister1 = 5'd5;
        ReadData1 = 32'h0BAD_0BAD;
        ReadRegister2 = 5'd6;
        ReadData2 = 32'h0000_0066;
        DestRegister = 5'd8;
        #1;
        total++;
        if (HazardStall !== 1'b1) begin
            $display("FAIL hazard_req got %b want 1", HazardStall);
        end else passed++;
        step();
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutDest} !== 8'd0
            || HazardStall !== 1'b0) begin
            $display("FAIL bubble got %b hs=%b want 0/0",
                     {OutValid, OutRegWrite, OutMemRead, OutDest},
                     HazardStall);
        end else passed++;
        MemWbRegWrite = 1'b1;
        MemWbDest = 5'd5;
        MemWbResult = 32'h5A5A_0005;
        step();
        total++;
        if (OutValid !== 1'b1 || OperandA !== 32'h5A5A_0005
            || FwdSelA !== 2'd2 || OutDest !== 5'd8) begin
            $display("FAIL after_hazard got v=%b %h/%0d d=%0d want 1 5a5a0005/2 8",
                     OutValid, OperandA, FwdSelA, OutDest);
        end else passed++;
    endtask

    task automatic test_flush_stall();
        logic [31:0] ha;
        logic [31:0] hb;
        clear_inputs();
        InValid = 1'b1;
        RegWriteIn = 1'b1;
        ReadRegister1 = 5'd10;
        ReadData1 = 32'h0000_00A1;
        ReadRegister2 = 5'd11;
        ReadData2 = 32'h0000_00B2;
        DestRegister = 5'd13;
        step();
        ha = 32'h0000_00A1;
        hb = 32'h0000_00B2;
        for (int i = 0; i < 3; i++) begin
            Stall = 1'b1;
            ReadData1 = 32'h7700_0000 + i;
            ReadData2 = 32'h8800_0000 + i;
            DestRegister = 5'd20;
            InValid = 1'b0;
            step();
            total++;
            if (OutValid !== 1'b1 || OutRegWrite !== 1'b1
                || OperandA !== ha || OperandB !== hb
                || OutDest !== 5'd13) begin
                $display("FAIL stall_hold%0d got v=%b w=%b %h %h d=%0d want 1 1 %h %h 13",
                         i, OutValid, OutRegWrite, OperandA, OperandB,
                         OutDest, ha, hb);
            end else passed++;
        end
        Flush = 1'b1;
        Stall = 1'b1;
        step();
        total++;
        if ({OutValid, OutRegWrite, OutMemRead, OutDest, FwdSelA, FwdSelB}
            !== 12'd0 || {OperandA, OperandB, StoreData} !== 96'd0) begin
            $display("FAIL flush got v=%b %h %h %h d=%0d want all 0",
                     OutValid, OperandA, OperandB, StoreData, OutDest);
        end else passed++;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        InValid = 1'b1;
        RegWriteIn = 1'b1;
        ReadRegister1 = 5'd4;
        ReadData1 = 32'h4444_4444;
        DestRegister = 5'd4;
        step();
        total++;
        if (OutValid !== 1'b1 || OperandA !== 32'h4444_4444) begin
            $display("FAIL pre_reset got %b/%h want 1/44444444",
                     OutValid, OperandA);
        end else passed++;
        #2;
        Rst_n = 1'b0;
        #1;
        total++;
        if (OutValid !== 1'b0 || OperandA !== 32'd0
            || OutRegWrite !== 1'b0 || OutDest !== 5'd0) begin
            $display("FAIL async_reset got v=%b %h w=%b d=%0d want 0",
                     OutValid, OperandA, OutRegWrite, OutDest);
        end else passed++;
        step();
        Rst_n = 1'b1;
        step();
        total++;
        if (OutValid !== 1'b1 || OperandA !== 32'h4444_4444) begin
            $display("FAIL post_reset got %b/%h want 1/44444444",
                     OutValid, OperandA);
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        Rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_no_forward();
        test_double_match();
        test_reg_zero();
        test_invalid_capture();
        test_load_use();
        test_flush_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: ports Clk (rising edge) and Rst_n (asserted low, takes effect immediately, released synchronously to Clk).
REQ-002 Clk  in  1  pipeline clock.
REQ-003 Rst_n  in  1  async active-low reset.
REQ-004 InValid  in  1  decode slot holds a real instruction.
REQ-005 Stall  in  1  downstream hold request; freezes stage.
REQ-006 Flush  in  1  squash instruction captured this edge.
REQ-007 ReadRegister1, ReadRegister2  in  5 each  source register numbers presented to the register file.
REQ-008 ReadData1, ReadData2  in  32 each  register file read data.
REQ-009 DestRegister  in  5  destination register of decoded instruction.
REQ-010 RegWriteIn, MemReadIn, UseImm  in  1 each  decoded controls; UseImm selects Imm for operand B.
REQ-011 Imm  in  32  sign-extended immediate.
REQ-012 ExMemRegWrite, MemWbRegWrite  in  1 each  later-stage write enables.
REQ-013 ExMemDest, MemWbDest  in  5 each  later-stage destination numbers.
REQ-014 ExMemResult, MemWbResult  in  32 each  later-stage results.
REQ-015 OutValid, OutRegWrite, OutMemRead  out  1 each  registered controls.
REQ-016 OperandA, OperandB, StoreData  out  32 each  registered operands; StoreData is forwarded source 2 regardless of UseImm.
REQ-017 OutDest  out  5  registered destination.
REQ-018 FwdSelA, FwdSelB  out  2 each  registered forward source: 0 regfile, 1 ExMem, 2 MemWb.
REQ-019 HazardStall  out  1  combinational load-use stall request to decode.

Function
REQ-020 Forward select for source n (combinational, pre-capture): 1 if ExMemRegWrite and ExMemDest==ReadRegistern and ReadRegistern!=0; else 2 if MemWbRegWrite and MemWbDest==ReadRegistern and ReadRegistern!=0; else 0.
REQ-021 ExMem SHALL win when ExMem and MemWb both match the same register.
REQ-022 Source register 0 SHALL never forward; value captured is ReadData as supplied.
REQ-023 MemWb forwarding SHALL cover the same-cycle write/read case, so correct operands never depend on register file internal bypass.
REQ-024 HazardStall = OutValid and OutMemRead and InValid and OutDest!=0 and (OutDest==ReadRegister1 or (OutDest==ReadRegister2 and not UseImm) or OutDest==ReadRegister2 with store use); simplest rule: match on either source, UseImm ignored.
REQ-025 Priority per rising edge: Flush > Stall > HazardStall > normal capture.
REQ-026 Flush: OutValid, OutRegWrite, OutMemRead <= 0; data outputs, OutDest, FwdSel <= 0.
REQ-027 Stall (no Flush): all outputs hold previous value.
REQ-028 HazardStall (no Flush/Stall): insert bubble: OutValid, OutRegWrite, OutMemRead <= 0, OutDest <= 0; decode holds its inputs.
REQ-029 Normal: OutValid <= InValid; controls/dest/FwdSel/operands captured; OperandB = UseImm ? Imm : forwarded source 2.
REQ-030 InValid=0 in normal capture SHALL force OutRegWrite and OutMemRead to 0.
REQ-031 Latency one cycle; no internal arithmetic; all data paths 32 bits, no truncation.

Reset
REQ-032 While Rst_n=0 all outputs SHALL be 0 (HazardStall 0 since OutValid 0); reset mid-stall or mid-hazard discards the held instruction.
REQ-033 First capture occurs on the first rising Clk with Rst_n=1.

Verification
REQ-034 No forwarding: ReadRegister1=16, ReadData1=DEADDAD5, no later-stage match -> next cycle OperandA=DEADDAD5, FwdSelA=0.
REQ-035 Double match: ReadRegister1=31, ExMem(31,11111111), MemWb(31,22222222) -> OperandA=11111111, FwdSelA=1.
REQ-036 Register 0: ReadRegister2=0, ExMemDest=0 with ExMemRegWrite=1, ExMemResult=FFFFFFFF, ReadData2=0 -> OperandB=0, FwdSelB=0.
REQ-037 Load-use: stage holds load OutDest=5, decode reads register 5 -> HazardStall=1, next cycle OutValid=0, following cycle instruction captured with MemWb forward.
REQ-038 Flush with Stall both high -> OutValid=0, all data 0; Stall alone -> outputs unchanged for 3 cycles.
REQ-039 Assert Rst_n=0 mid-cycle while OutValid=1 -> outputs 0 immediately, before next Clk edge.
